// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, oversampling constant and divisor helper
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam int OVS = 16;

    function automatic int rx_div(input int sys_clk, input int rate);
        return sys_clk / (rate * OVS);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running divider emitting a one-cycle enable every DIV clocks
module uart_baud_tick #(
    parameter int DIV = 91
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling 8N1 receiver with held byte, valid/read handshake and error flags
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYS_CLK = 14000000,
    parameter int RATE    = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rd,
    output logic [7:0] dout,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV = rx_div(SYS_CLK, RATE);

    logic       rx_meta;
    logic       rxs;
    logic       tick;
    rx_state_t  state;
    logic [3:0] scnt;
    logic [2:0] bcnt;
    logic [7:0] shreg;
    logic       stop_ok;
    logic       load;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    // A good stop bit is accepted into dout only if the old byte is gone or being read now.
    always_comb begin
        stop_ok = 1'b0;
        if (tick && state == ST_STOP && scnt == 4'd15 && rxs)
            stop_ok = 1'b1;
        load = stop_ok && (!valid || rd);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            scnt      <= 4'd0;
            bcnt      <= 3'd0;
            shreg     <= 8'h00;
            dout      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            if (load) begin
                dout  <= shreg;
                valid <= 1'b1;
                if (rd)
                    overrun <= 1'b0;
            end else if (stop_ok) begin
                overrun <= 1'b1;
            end else if (rd && valid) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end

            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        scnt <= 4'd0;
                        if (!rxs)
                            state <= ST_START;
                    end
                    ST_START: begin
                        if (scnt == 4'd7) begin
                            scnt <= 4'd0;
                            bcnt <= 3'd0;
                            state <= rxs ? ST_IDLE : ST_DATA;
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                    ST_DATA: begin
                        scnt <= scnt + 4'd1;
                        if (scnt == 4'd15) begin
                            shreg <= {rxs, shreg[7:1]};
                            bcnt  <= bcnt + 3'd1;
                            if (bcnt == 3'd7)
                                state <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        scnt <= scnt + 4'd1;
                        if (scnt == 4'd15) begin
                            if (rxs) begin
                                state <= ST_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= ST_BREAK;
                            end
                        end
                    end
                    ST_BREAK: begin
                        scnt <= 4'd0;
                        if (rxs)
                            state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        scnt  <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at a reduced bit rate
module tb_uart_rx;
    import uart_pkg::*;

    localparam int SYS_CLK = 96;
    localparam int RATE    = 2;
    localparam int DIV     = 3;
    localparam int BIT     = DIV * 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] dout;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    int   valid_rises = 0;
    int   fe_rises    = 0;
    int   fe_high     = 0;
    logic valid_q     = 1'b0;
    logic fe_q        = 1'b0;

    uart_rx #(.SYS_CLK(SYS_CLK), .RATE(RATE)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rd        (rd),
        .dout      (dout),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        valid_q <= valid;
        fe_q    <= frame_err;
        if (valid && !valid_q)
            valid_rises <= valid_rises + 1;
        if (frame_err && !fe_q)
            fe_rises <= fe_rises + 1;
        if (frame_err)
            fe_high <= fe_high + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        clks(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(d[i]);
        drive_bit(stop_bit);
        rxd = 1'b1;
    endtask

    task automatic do_read();
        rd = 1'b1;
        clks(1);
        rd = 1'b0;
        clks(1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         vr0;
        int         fr0;
        int         fh0;
        logic [7:0] b;

        clks(5);
        check("reset_dout", dout, 8'h00);
        check("reset_valid", valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        reset = 1'b1;
        clks(BIT);

        // single byte
        vr0 = valid_rises; fr0 = fe_rises;
        send_frame(8'h55, 1'b1);
        check("b55_rises", valid_rises - vr0, 1);
        check("b55_dout", dout, 8'h55);
        check("b55_valid", valid, 1'b1);
        check("b55_fe", fe_rises - fr0, 0);
        check("b55_overrun", overrun, 1'b0);
        do_read();
        check("b55_read_valid", valid, 1'b0);

        // back-to-back without read: second byte dropped
        vr0 = valid_rises;
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        check("ovr_dout", dout, 8'hA5);
        check("ovr_valid", valid, 1'b1);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_rises", valid_rises - vr0, 1);
        do_read();
        check("ovr_read_valid", valid, 1'b0);
        check("ovr_read_overrun", overrun, 1'b0);

        // 5-tick low glitch is a false start
        vr0 = valid_rises;
        rxd = 1'b0;
        clks(5 * DIV);
        rxd = 1'b1;
        clks(2 * BIT);
        check("glitch_rises", valid_rises - vr0, 0);
        check("glitch_idle", 32'(dut.state), 32'(ST_IDLE));
        send_frame(8'h81, 1'b1);
        check("glitch_next_dout", dout, 8'h81);
        check("glitch_next_rises", valid_rises - vr0, 1);
        do_read();

        // bad stop bit followed by a held-low line
        vr0 = valid_rises; fr0 = fe_rises; fh0 = fe_high;
        send_frame(8'hFF, 1'b0);
        rxd = 1'b0;
        clks(3 * BIT);
        rxd = 1'b1;
        clks(BIT);
        check("brk_fe_pulses", fe_rises - fr0, 1);
        check("brk_fe_width", fe_high - fh0, 1);
        check("brk_valid", valid, 1'b0);
        check("brk_rises", valid_rises - vr0, 0);
        send_frame(8'h12, 1'b1);
        check("brk_next_dout", dout, 8'h12);
        check("brk_next_rises", valid_rises - vr0, 1);
        check("brk_next_fe", fe_rises - fr0, 1);
        do_read();

        // reset in the middle of data bit 4 of 0xC3
        b = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++)
            drive_bit(b[i]);
        rxd = b[4];
        clks(BIT / 2);
        reset = 1'b0;
        clks(2);
        check("rst_dout", dout, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_fe", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_state", 32'(dut.state), 32'(ST_IDLE));
        rxd = 1'b1;
        clks(3);
        reset = 1'b1;
        clks(BIT);
        vr0 = valid_rises;
        send_frame(8'h7E, 1'b1);
        check("rst_next_dout", dout, 8'h7E);
        check("rst_next_valid", valid, 1'b1);
        check("rst_next_rises", valid_rises - vr0, 1);
        do_read();

        // stream of bytes, each read as soon as it arrives
        fr0 = fe_rises;
        for (int i = 0; i < 32; i++) begin
            if (i == 0)
                b = 8'h00;
            else if (i == 31)
                b = 8'hFF;
            else
                b = 8'(i * 37 + 5);
            send_frame(b, 1'b1);
            check("loop_valid", valid, 1'b1);
            check("loop_byte", dout, b);
            do_read();
        end
        check("loop_fe", fe_rises - fr0, 0);
        check("loop_overrun", overrun, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
